// File: rtl/pipe_trace_buffer_pkg.sv
// Shared types and record layout for the mips32 pipeline trace buffer.
// The standard record packs the mips_32 debug ports with the PC in the most significant field.
package mips32_trace_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } trace_state_t;

   localparam int unsigned FWD_W     = 2;
   localparam int unsigned FWD_B_LSB = 0;
   localparam int unsigned FWD_A_LSB = FWD_B_LSB + FWD_W;
   localparam int unsigned STALL_BIT = FWD_A_LSB + FWD_W;
   localparam int unsigned INST_W    = 32;
   localparam int unsigned INST_LSB  = STALL_BIT + 1;
   localparam int unsigned PC_W      = 32;
   localparam int unsigned PC_LSB    = INST_LSB + INST_W;
   localparam int unsigned STD_REC_W = PC_LSB + PC_W;

   function automatic logic [STD_REC_W-1:0] pack_std_record(
      input logic [PC_W-1:0]   pc,
      input logic [INST_W-1:0] inst,
      input logic              stall,
      input logic [FWD_W-1:0]  fwd_a,
      input logic [FWD_W-1:0]  fwd_b
   );
      return {pc, inst, stall, fwd_a, fwd_b};
   endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// DEPTH x REC_W trace storage: one write port, one registered read port.
// Only the read register is reset; the array itself stays reset-free so it can map to distributed RAM.
module trace_ram #(
   parameter  int unsigned REC_W = 64,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [REC_W-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [REC_W-1:0] rdata
);

   logic [REC_W-1:0] mem_q [DEPTH];
   logic [REC_W-1:0] rdata_q;
   logic [REC_W-1:0] rdata_d;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular pipeline trace capture: masked-compare trigger, programmable post-trigger depth,
// oldest-first readout once capture has completed.
module pipe_trace_buffer
   import mips32_trace_pkg::*;
#(
   parameter int unsigned REC_W = 64,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             arm,
   input  logic             sample_valid,
   input  logic [REC_W-1:0] sample_data,
   input  logic [REC_W-1:0] trig_value,
   input  logic [REC_W-1:0] trig_mask,
   input  logic [CNT_W-1:0] post_count,
   input  logic             rd_req,
   output logic [REC_W-1:0] rd_data,
   output logic             rd_valid,
   output logic             rd_last,
   output logic             triggered,
   output logic             done,
   output logic [CNT_W-1:0] fill
);

   localparam int unsigned      AW       = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] MAX_POST = CNT_W'(DEPTH - 1);

   trace_state_t     state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] fill_q, fill_d;
   logic [CNT_W-1:0] post_cnt_q, post_cnt_d;
   logic             rd_valid_q, rd_valid_d;
   logic             rd_last_q, rd_last_d;
   logic             triggered_q, triggered_d;
   logic             done_q, done_d;

   logic             hit;
   logic             wr_en;
   logic             rd_accept;
   logic [AW-1:0]    rd_base;
   logic [AW-1:0]    rd_addr;

   // rd_ptr counts records already read; the physical address is offset from the oldest slot.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fill_d      = fill_q;
      post_cnt_d  = post_cnt_q;
      triggered_d = triggered_q;
      done_d      = done_q;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
      wr_en       = 1'b0;
      rd_accept   = 1'b0;
      hit         = sample_valid && (((sample_data ^ trig_value) & trig_mask) == '0);
      rd_base     = (fill_q == FULL) ? wr_ptr_q : '0;
      rd_addr     = rd_base + rd_ptr_q[AW-1:0];

      if (arm) begin
         state_d     = ARMED;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         fill_d      = '0;
         triggered_d = 1'b0;
         done_d      = 1'b0;
         post_cnt_d  = (post_count > MAX_POST) ? MAX_POST : post_count;
      end else begin
         case (state_q)
            ARMED, POST: begin
               if (sample_valid) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  fill_d   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
                  if (state_q == ARMED) begin
                     if (hit) begin
                        triggered_d = 1'b1;
                        if (post_cnt_q == '0) begin
                           state_d = DONE;
                           done_d  = 1'b1;
                        end else begin
                           state_d = POST;
                        end
                     end
                  end else begin
                     post_cnt_d = post_cnt_q - 1'b1;
                     if (post_cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               if (rd_req && (rd_ptr_q < fill_q)) begin
                  rd_accept  = 1'b1;
                  rd_valid_d = 1'b1;
                  rd_last_d  = ((rd_ptr_q + 1'b1) == fill_q);
                  rd_ptr_d   = rd_ptr_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         post_cnt_q  <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
         post_cnt_q  <= post_cnt_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
         triggered_q <= triggered_d;
         done_q      <= done_d;
      end
   end

   trace_ram #(
      .REC_W (REC_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (sample_data),
      .re    (rd_accept),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   assign rd_valid  = rd_valid_q;
   assign rd_last   = rd_last_q;
   assign triggered = triggered_q;
   assign done      = done_q;
   assign fill      = fill_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Scoreboard bench for pipe_trace_buffer: a queue-based history model predicts fill/trigger/done
// each cycle and the expected readout stream, which a negedge monitor compares against rd_* outputs.
module tb_pipe_trace_buffer;

   localparam int unsigned REC_W = 64;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CNT_W = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             arm = 1'b0;
   logic             sample_valid = 1'b0;
   logic [REC_W-1:0] sample_data = '0;
   logic [REC_W-1:0] trig_value = '0;
   logic [REC_W-1:0] trig_mask = '0;
   logic [CNT_W-1:0] post_count = '0;
   logic             rd_req = 1'b0;
   logic [REC_W-1:0] rd_data;
   logic             rd_valid;
   logic             rd_last;
   logic             triggered;
   logic             done;
   logic [CNT_W-1:0] fill;

   pipe_trace_buffer #(
      .REC_W (REC_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .arm          (arm),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .trig_value   (trig_value),
      .trig_mask    (trig_mask),
      .post_count   (post_count),
      .rd_req       (rd_req),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_last      (rd_last),
      .triggered    (triggered),
      .done         (done),
      .fill         (fill)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [REC_W-1:0] data;
      bit               last;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: stored history as an oldest-first queue capped at DEPTH entries.
   logic [REC_W-1:0] hist[$];
   bit m_cap  = 0;
   bit m_trig = 0;
   bit m_done = 0;
   int m_post = 0;
   int m_rd   = 0;

   task automatic chk(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rd_valid: got rd_valid=1 expected no pending record at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rd_data", rd_data, e.data);
            chk("rd_last", {63'd0, rd_last}, {63'd0, e.last});
         end
      end
   end

   task automatic step(input bit a, input bit v, input logic [REC_W-1:0] d, input bit r);
      bit done_pre;
      bit hit;
      arm = a;
      sample_valid = v;
      sample_data = d;
      rd_req = r;
      @(posedge clk);
      done_pre = m_done;
      hit = v && (((d ^ trig_value) & trig_mask) == '0);
      if (reset) begin
         hist.delete();
         m_cap = 0; m_trig = 0; m_done = 0; m_post = 0; m_rd = 0;
      end else if (a) begin
         hist.delete();
         m_cap = 1; m_trig = 0; m_done = 0; m_rd = 0;
         m_post = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
      end else begin
         if (m_cap && v) begin
            hist.push_back(d);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            if (!m_trig) begin
               if (hit) begin
                  m_trig = 1;
                  if (m_post == 0) begin m_cap = 0; m_done = 1; end
               end
            end else begin
               m_post--;
               if (m_post == 0) begin m_cap = 0; m_done = 1; end
            end
         end
         if (done_pre && r && m_rd < hist.size()) begin
            exp_q.push_back('{hist[m_rd], (m_rd == hist.size() - 1)});
            m_rd++;
         end
      end
      #1;
      chk("fill", {59'd0, fill}, 64'(hist.size()));
      chk("triggered", {63'd0, triggered}, {63'd0, m_trig});
      chk("done", {63'd0, done}, {63'd0, m_done});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(0, 0, '0, 0);
      chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
      chk("rst_rd_last", {63'd0, rd_last}, 64'd0);
      chk("rst_rd_data", rd_data, 64'd0);
      reset = 1'b0;
   endtask

   task automatic arm_cfg(input logic [REC_W-1:0] tv, input logic [REC_W-1:0] tm, input int pc);
      trig_value = tv;
      trig_mask = tm;
      post_count = CNT_W'(pc);
      step(1, 0, '0, 0);
   endtask

   task automatic read_n(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, 1);
      step(0, 0, '0, 0);
   endtask

   initial begin
      do_reset();

      // 1: mask 0, post 3, samples 0x10..0x13
      arm_cfg(64'h0, 64'h0, 3);
      for (int i = 0; i < 4; i++) step(0, 1, 64'h10 + 64'(i), 0);
      step(0, 1, 64'h99, 0);
      read_n(6);

      // 2: trigger on 0x40 after a wrapped history
      arm_cfg(64'h40, 64'hFFFF, 5);
      for (int i = 0; i < 'h50; i++) step(0, 1, 64'(i), 0);
      read_n(18);

      // 3: invalid cycles interleaved during POST
      arm_cfg(64'hABCD, 64'hFFFF, 2);
      step(0, 1, 64'h1111, 0);
      step(0, 1, 64'hABCD, 0);
      for (int i = 0; i < 6; i++) step(0, i[0], 64'h2000 + 64'(i), 0);
      step(0, 1, 64'h3000, 0);
      read_n(5);

      // 4: arm coinciding with a matching sample
      trig_value = 64'h77; trig_mask = '1; post_count = CNT_W'(1);
      step(1, 1, 64'h77, 0);
      step(0, 1, 64'h76, 0);
      step(0, 1, 64'h77, 0);
      step(0, 1, 64'h78, 0);
      read_n(4);

      // 5: post_count beyond DEPTH is clipped
      arm_cfg(64'h0, 64'h0, 31);
      for (int i = 0; i < 20; i++) step(0, 1, 64'h500 + 64'(i), 0);
      read_n(20);

      // 6: reset in the middle of POST
      arm_cfg(64'h0, 64'h0, 10);
      for (int i = 0; i < 7; i++) step(0, 1, 64'h600 + 64'(i), 0);
      do_reset();
      read_n(3);

      // 7: randomized captures with readout overlapping capture and occasional re-arm
      for (int it = 0; it < 8; it++) begin
         arm_cfg(64'($urandom_range(0, 7)), 64'h7, $urandom_range(0, 31));
         for (int c = 0; c < 70; c++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
                 {$urandom, $urandom}, $urandom_range(0, 1));
         end
         read_n(20);
      end

      for (int i = 0; i < 4; i++) step(0, 0, '0, 0);
      chk("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
